// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver
//
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// A free-running refresh counter steps a 2-bit scan index across the digits.
// All inputs are copied into shadow registers once per frame so that the
// display never tears mid-frame. The digit selected by the edit cursor can
// be blinked.
//
// Ports:
//   clk           in   system clock (100 MHz nominal)
//   reset_n       in   synchronous, active-low reset
//   ones          in   [3:0] ones digit, BCD
//   tens          in   [3:0] tens digit, BCD
//   hundreds      in   [3:0] hundreds digit, BCD
//   sign          in   1 = value is negative
//   input_status  in   0 = operand A, 1 = operand B (lit on the sign digit dp)
//   unit          in   [1:0] cursor: 0 ones, 1 tens, 2 hundreds, 3 sign
//   blink_en      in   enables blinking of the cursor digit
//   an            out  [3:0] digit enables, active-low, an[0] = rightmost
//   seg           out  [6:0] segments {g,f,e,d,c,b,a}, active-low
//   dp            out  decimal point, active-low
// ---------------------------------------------------------------------------
module seg7_scan_driver #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] ones,
  input  logic [3:0] tens,
  input  logic [3:0] hundreds,
  input  logic       sign,
  input  logic       input_status,
  input  logic [1:0] unit,
  input  logic       blink_en,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;

  // Timing state
  logic [REF_W-1:0] refresh_cnt;
  logic [1:0]       scan_idx;
  logic [BLK_W-1:0] blink_cnt;
  logic             blink_on;

  // Frame shadow copies of the inputs
  logic [3:0] sh_ones;
  logic [3:0] sh_tens;
  logic [3:0] sh_hundreds;
  logic       sh_sign;
  logic       sh_status;
  logic [1:0] sh_unit;

  logic       refresh_wrap;
  logic       blink_wrap;
  logic       frame_wrap;

  logic [3:0] digit_sel;
  logic       blank_slot;
  logic [3:0] an_next;
  logic [6:0] seg_next;
  logic       dp_next;

  // BCD to active-low gfedcba; codes 10..15 render as 'E'.
  function automatic logic [6:0] decode_bcd(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_E;
    endcase
    return s;
  endfunction

  assign refresh_wrap = (refresh_cnt == REF_LAST);
  assign blink_wrap   = (blink_cnt == BLK_LAST);
  // Last slot of a frame is ending: new inputs become visible from slot 0.
  assign frame_wrap   = refresh_wrap && (scan_idx == 2'd3);

  // Output image for the slot currently selected by scan_idx.
  always_comb begin
    digit_sel = sh_ones;
    case (scan_idx)
      2'd0:    digit_sel = sh_ones;
      2'd1:    digit_sel = sh_tens;
      2'd2:    digit_sel = sh_hundreds;
      default: digit_sel = 4'd0;
    endcase

    an_next = ~(4'b0001 << scan_idx);

    if (scan_idx == 2'd3) begin
      seg_next = sh_sign ? SEG_MINUS : SEG_BLANK;
    end else begin
      seg_next = decode_bcd(digit_sel);
    end

    // The operand-B marker lives on the sign digit's decimal point.
    dp_next = !((scan_idx == 2'd3) && sh_status);

    // Cursor slot goes fully dark during the off half of the blink period.
    blank_slot = blink_en && !blink_on && (scan_idx == sh_unit);
    if (blank_slot) begin
      an_next  = 4'b1111;
      seg_next = SEG_BLANK;
      dp_next  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      refresh_cnt <= '0;
      scan_idx    <= 2'd0;
      blink_cnt   <= '0;
      blink_on    <= 1'b1;
      sh_ones     <= 4'd0;
      sh_tens     <= 4'd0;
      sh_hundreds <= 4'd0;
      sh_sign     <= 1'b0;
      sh_status   <= 1'b0;
      sh_unit     <= 2'd0;
      an          <= 4'b1111;
      seg         <= SEG_BLANK;
      dp          <= 1'b1;
    end else begin
      if (refresh_wrap) begin
        refresh_cnt <= '0;
        scan_idx    <= scan_idx + 2'd1;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end

      if (frame_wrap) begin
        sh_ones     <= ones;
        sh_tens     <= tens;
        sh_hundreds <= hundreds;
        sh_sign     <= sign;
        sh_status   <= input_status;
        sh_unit     <= unit;
      end

      // Free-running; blink_en only masks the effect on the display.
      if (blink_wrap) begin
        blink_cnt <= '0;
        blink_on  <= !blink_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end

      an  <= an_next;
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// Testbench for seg7_scan_driver with REFRESH_DIV=4, BLINK_DIV=16.
// Edge k is the k-th clock edge after reset release (edge 1 is the first one
// that samples reset_n=1). The outputs after edge k show slot
// (k-1)/4 mod 4, new shadow values appear from edge 16f+1 of frame f, and the
// blink is in its off half when (k-1)/16 is odd.
// ---------------------------------------------------------------------------
module tb_seg7_scan_driver;

  localparam int unsigned REFRESH_DIV = 4;
  localparam int unsigned BLINK_DIV   = 16;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] ones;
  logic [3:0] tens;
  logic [3:0] hundreds;
  logic       sign;
  logic       input_status;
  logic [1:0] unit;
  logic       blink_en;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  seg7_scan_driver #(
    .REFRESH_DIV (REFRESH_DIV),
    .BLINK_DIV   (BLINK_DIV)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ones         (ones),
    .tens         (tens),
    .hundreds     (hundreds),
    .sign         (sign),
    .input_status (input_status),
    .unit         (unit),
    .blink_en     (blink_en),
    .an           (an),
    .seg          (seg),
    .dp           (dp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Edge k after release lands on absolute cycle base + k (3 reset edges).
  int base = 3;

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  localparam logic [6:0] S_0     = 7'b1000000;
  localparam logic [6:0] S_1     = 7'b1111001;
  localparam logic [6:0] S_2     = 7'b0100100;
  localparam logic [6:0] S_3     = 7'b0110000;
  localparam logic [6:0] S_5     = 7'b0010010;
  localparam logic [6:0] S_7     = 7'b1111000;
  localparam logic [6:0] S_E     = 7'b0000110;
  localparam logic [6:0] S_MINUS = 7'b0111111;
  localparam logic [6:0] S_BLANK = 7'b1111111;

  task automatic expect_at(input int k, input logic [3:0] an_e,
                           input logic [6:0] seg_e, input logic dp_e,
                           input string name);
    exp_t e;
    e.cyc  = base + k;
    e.an   = an_e;
    e.seg  = seg_e;
    e.dp   = dp_e;
    e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic wait_k(input int k);
    while (cyc < base + k) @(negedge clk);
  endtask

  // Monitor: outputs are sampled on the falling edge, after the registers
  // settled; every expectation whose cycle has arrived is popped and checked.
  always @(negedge clk) begin
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      n_cmp = n_cmp + 1;
      if (e.cyc != cyc || an !== e.an || seg !== e.seg || dp !== e.dp) begin
        n_err = n_err + 1;
        $display("FAIL %s @cyc %0d (due %0d): an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                 e.name, cyc, e.cyc, an, seg, dp, e.an, e.seg, e.dp);
      end
    end
  end

  initial begin
    reset_n      = 1'b0;
    ones         = 4'd3;
    tens         = 4'd2;
    hundreds     = 4'd1;
    sign         = 1'b1;
    input_status = 1'b0;
    unit         = 2'd0;
    blink_en     = 1'b0;

    // Reset held for three edges, then first frame shows shadow zeros.
    expect_at(-2, 4'b1111, S_BLANK, 1'b1, "rst_hold1");
    expect_at(-1, 4'b1111, S_BLANK, 1'b1, "rst_hold2");
    expect_at( 0, 4'b1111, S_BLANK, 1'b1, "rst_hold3");
    expect_at( 1, 4'b1110, S_0,     1'b1, "rst_release");
    expect_at( 4, 4'b1110, S_0,     1'b1, "f0_idx0_end");
    expect_at( 5, 4'b1101, S_0,     1'b1, "f0_idx1");
    expect_at(13, 4'b0111, S_BLANK, 1'b1, "f0_sign_blank");
    // Frame 1: inputs latched at edge 16, every clock of the frame checked.
    for (int k = 17; k <= 20; k++) expect_at(k, 4'b1110, S_3,     1'b1, "f1_ones");
    for (int k = 21; k <= 24; k++) expect_at(k, 4'b1101, S_2,     1'b1, "f1_tens");
    for (int k = 25; k <= 28; k++) expect_at(k, 4'b1011, S_1,     1'b1, "f1_hund");
    for (int k = 29; k <= 32; k++) expect_at(k, 4'b0111, S_MINUS, 1'b1, "f1_sign");

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Shadow latch: mid-frame changes wait for the next frame.
    wait_k(18);
    tens = 4'd5;
    expect_at(33, 4'b1110, S_7,     1'b1, "f2_ones_new");
    expect_at(36, 4'b1110, S_7,     1'b1, "f2_ones_end");
    expect_at(37, 4'b1101, S_5,     1'b1, "f2_tens_new");
    expect_at(41, 4'b1011, S_1,     1'b1, "f2_hund");
    expect_at(45, 4'b0111, S_MINUS, 1'b1, "f2_sign");
    wait_k(21);
    ones = 4'd7;

    // Blink on tens digit; cursor latched at edge 48, frame 3 is an off half.
    wait_k(34);
    unit     = 2'd1;
    blink_en = 1'b1;
    expect_at(49, 4'b1110, S_7, 1'b1, "f3_ones_vis");
    for (int k = 53; k <= 56; k++) expect_at(k, 4'b1111, S_BLANK, 1'b1, "f3_tens_blank");
    expect_at(57, 4'b1011, S_1,     1'b1, "f3_hund_vis");
    expect_at(61, 4'b0111, S_MINUS, 1'b1, "f3_sign_vis");
    expect_at(69, 4'b1101, S_5,     1'b1, "f4_tens_on");

    // Blink disabled, operand B and invalid hundreds digit.
    wait_k(72);
    blink_en     = 1'b0;
    input_status = 1'b1;
    hundreds     = 4'd12;
    expect_at(81, 4'b1110, S_7, 1'b1, "f5_ones_dp");
    for (int k = 85; k <= 88; k++) expect_at(k, 4'b1101, S_5, 1'b1, "f5_tens_noblink");
    expect_at(89, 4'b1011, S_E,     1'b1, "f5_hund_E");
    expect_at(93, 4'b0111, S_MINUS, 1'b0, "f5_sign_dp");
    expect_at(97,  4'b1110, S_7, 1'b1, "f6_ones");
    expect_at(101, 4'b1101, S_5, 1'b1, "f6_tens");
    expect_at(105, 4'b1011, S_E, 1'b1, "f6_hund");
    // Reset mid-scan at slot 2; restart at slot 0 with cleared shadows.
    expect_at(106, 4'b1111, S_BLANK, 1'b1, "midrst");
    expect_at(107, 4'b1110, S_0,     1'b1, "post_rst_idx0");
    expect_at(111, 4'b1101, S_0,     1'b1, "post_rst_idx1");
    expect_at(115, 4'b1011, S_0,     1'b1, "post_rst_idx2");
    expect_at(119, 4'b0111, S_BLANK, 1'b1, "post_rst_idx3");

    wait_k(105);
    reset_n = 1'b0;
    wait_k(106);
    reset_n = 1'b1;

    wait_k(122);
    if (sb_q.size() != 0) begin
      n_cmp = n_cmp + 1;
      n_err = n_err + 1;
      $display("FAIL sb_leftover: %0d entries unchecked, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
